rf_hop_sched: RTL and testbench
===============================

# rf_hop_sched

Frequency-hop scheduler that drives the RF parallel-control block. It holds a host-programmable table of 16-bit frequency words and issues one word per CPI as a single-cycle valid pulse. Entry 0 is issued on init. Each later entry is issued after the current CPI's transmission completes, wrapping around the programmed hop length. It sits between the host config path and the RF parallel-control block. It shares `i_init`, `i_stop`, `i_pre_cpi` and `i_tx_over_flag` with that block.

## Interface
Parameters:
- `DEPTH`, 16: number of hop-table entries.
- `ADDR_W`, 4: table address width, equal to clog2(DEPTH).
- `FREQ_W`, 16: frequency word width.

Ports (clock and reset first):
- `clk`  in  1: single system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `i_cfg_we`  in  1: table write strobe.
- `i_cfg_addr`  in  ADDR_W: table write address.
- `i_cfg_data`  in  FREQ_W: table write data.
- `i_hop_len`  in  ADDR_W+1: number of active entries; sampled at init.
- `i_init`  in  1: start hopping sequence; single-cycle pulse.
- `i_stop`  in  1: abort sequence; single-cycle pulse.
- `i_pre_cpi`  in  1: pre-CPI level; asynchronous to the datapath.
- `i_tx_over_flag`  in  1: current CPI transmission finished; single-cycle pulse.
- `o_rf_freq`  out  FREQ_W: issued frequency word; held until the next issue.
- `o_rf_freq_vld`  out  1: 1-cycle strobe qualifying `o_rf_freq`.
- `o_hop_idx`  out  ADDR_W: table index of the last issued word.
- `o_busy`  out  1: high in every state except IDLE.
- `o_overrun`  out  1: sticky; a pre-CPI edge arrived before `tx_over` completed the previous CPI.
- `o_cfg_err`  out  1: 1-cycle pulse when an init is rejected.

## Operation
- `i_pre_cpi` passes through a 2-flop synchronizer, then a rising-edge detector. The edge pulse `pc_edge` is high exactly 3 cycles after `i_pre_cpi` rises, for 1 cycle.
- States:
  - IDLE: the reset state.
    - `i_init` with `1 <= i_hop_len <= DEPTH`: latch `i_hop_len` into `hop_len_r`, set `idx <= 0`, clear `o_overrun`, go to RD.
    - `i_init` with `i_hop_len` of 0 or greater than DEPTH: pulse `o_cfg_err`, stay in IDLE.
  - RD: drive table read address `idx`; the read data is registered. Go to ISSUE.
  - ISSUE: load `o_rf_freq` from the read data, set `o_hop_idx <= idx`, assert `o_rf_freq_vld` for 1 cycle. Go to WAIT_CPI.
  - WAIT_CPI:
    - `pc_edge`: go to WAIT_TX.
    - `i_tx_over_flag`: ignored.
  - WAIT_TX:
    - `i_tx_over_flag`: set `idx <= (idx == hop_len_r-1) ? 0 : idx+1`, go to RD.
    - `pc_edge`: set `o_overrun <= 1`, stay in WAIT_TX.
- `i_stop` in any state: next state is IDLE. No vld is issued afterwards. `o_rf_freq` and `o_hop_idx` hold their values. `i_stop` wins over `i_init` in the same cycle.
- `i_init` in a non-IDLE state: restarts the sequence as if from IDLE, including the length check. On rejection, the block pulses `o_cfg_err` and goes to IDLE.
- Simultaneous `pc_edge` and `i_tx_over_flag` in WAIT_TX: the tx_over is taken (advance to RD). `o_overrun` is not set.
- Table writes are accepted in every state. A write to the address being read in the same cycle returns the old data (read-before-write). A write lands in the next read of that address.
- Reset values: `o_rf_freq = 0`, `o_rf_freq_vld = 0`, `o_hop_idx = 0`, `o_busy = 0`, `o_overrun = 0`, `o_cfg_err = 0`. State is IDLE, `idx` and `hop_len_r` are 0, synchronizer flops are 0. Table contents are undefined.

## Timing
- `i_init` sampled at cycle t: RD at t+1, `o_rf_freq_vld` at t+2.
- `i_tx_over_flag` sampled at cycle t: next `o_rf_freq_vld` at t+2.
- `i_pre_cpi` rises before cycle t: `pc_edge` at t+3. The state changes to WAIT_TX at t+4.
- `o_busy` rises the cycle after an accepted init. It falls the cycle after `i_stop`.
- All outputs are registered. There is no combinational input-to-output path.

## Structure
- Package `rf_ctrl_pkg`: state enum `hop_state_t` (IDLE, RD, ISSUE, WAIT_CPI, WAIT_TX) and constant `RF_FREQ_W = 16`.
- Sub-module `rf_hop_table`:
  - DEPTH x FREQ_W simple dual-port RAM: 1 write port, 1 registered read port.
  - Read-before-write on address collision.
  - No reset on the storage array.
- Top level contains the synchronizer, edge detector, FSM and output registers.

## Test plan
- Basic issue:
  - Stimulus: write entries 0..2 = 0x1111, 0x2222, 0x3333; `hop_len = 3`; init at cycle 10.
  - Response: `o_rf_freq_vld` at cycle 12 with `o_rf_freq = 0x1111` and `o_hop_idx = 0`.
- Wrap-around:
  - Stimulus: 4 full pre_cpi→tx_over cycles with `hop_len = 3`.
  - Response: issued words 0x2222, 0x3333, 0x1111, 0x2222. Each vld comes 2 cycles after its tx_over.
- Overrun:
  - Stimulus: two `i_pre_cpi` rising edges with no tx_over between them.
  - Response: `o_overrun = 1` from 4 cycles after the second edge. No extra vld. `o_overrun` stays 1 until the next init.
- Stop beats init:
  - Stimulus: `i_stop` and `i_init` together in WAIT_TX.
  - Response: IDLE next cycle, `o_busy = 0`, no vld. `o_rf_freq` keeps its last value.
- Rejected init:
  - Stimulus: init with `hop_len = 0`, then init with `hop_len = 17`.
  - Response: each gives a 1-cycle `o_cfg_err` pulse, `o_busy` stays 0, no vld.
- Reset mid-run:
  - Stimulus: assert `rst_n = 0` asynchronously while in WAIT_CPI.
  - Response: all outputs are 0 immediately. A later init issues entry 0 with table contents preserved.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the RF control slice (hop scheduler and
// parallel-control block).
package rf_ctrl_pkg;

  localparam int RF_FREQ_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    ISSUE,
    WAIT_CPI,
    WAIT_TX
  } hop_state_t;

endpackage

// File: rtl/rf_hop_table.sv
// Hop-table RAM: one write port and one registered read port. A read and a
// write to the same address on the same edge returns the old word.
module rf_hop_table #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int FREQ_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [FREQ_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [FREQ_W-1:0] rd_data
);

  logic [FREQ_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register only loads on rd_en, so it holds the last issued word
  // and can serve directly as the scheduler's frequency output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rf_hop_sched.sv
// Frequency-hop scheduler: issues one table word per CPI to the RF
// parallel-control block, advancing on each completed transmission.
module rf_hop_sched
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int FREQ_W = RF_FREQ_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cfg_we,
  input  logic [ADDR_W-1:0] i_cfg_addr,
  input  logic [FREQ_W-1:0] i_cfg_data,
  input  logic [ADDR_W:0]   i_hop_len,
  input  logic              i_init,
  input  logic              i_stop,
  input  logic              i_pre_cpi,
  input  logic              i_tx_over_flag,
  output logic [FREQ_W-1:0] o_rf_freq,
  output logic              o_rf_freq_vld,
  output logic [ADDR_W-1:0] o_hop_idx,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_cfg_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  hop_state_t        state_q, state_nxt;
  logic [ADDR_W-1:0] idx_q, idx_nxt;
  logic [ADDR_W:0]   hop_len_q, hop_len_nxt;
  logic [ADDR_W:0]   last_idx;
  logic              overrun_nxt;
  logic              cfg_err_nxt;
  logic              issue;
  logic              len_ok;

  logic              pre_s1, pre_s2, pre_s3;
  logic              pc_edge;

  // Two-flop synchronizer plus a registered rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_s1  <= 1'b0;
      pre_s2  <= 1'b0;
      pre_s3  <= 1'b0;
      pc_edge <= 1'b0;
    end else begin
      pre_s1  <= i_pre_cpi;
      pre_s2  <= pre_s1;
      pre_s3  <= pre_s2;
      pc_edge <= pre_s2 & ~pre_s3;
    end
  end

  assign last_idx = hop_len_q - (ADDR_W+1)'(1);
  assign len_ok   = (i_hop_len != '0) && (i_hop_len <= DEPTH_L);

  // Stop beats init, and init (accepted or not) beats normal sequencing.
  always_comb begin
    state_nxt   = state_q;
    idx_nxt     = idx_q;
    hop_len_nxt = hop_len_q;
    overrun_nxt = o_overrun;
    cfg_err_nxt = 1'b0;
    issue       = 1'b0;
    if (i_stop) begin
      state_nxt = IDLE;
    end else if (i_init) begin
      if (len_ok) begin
        state_nxt   = RD;
        idx_nxt     = '0;
        hop_len_nxt = i_hop_len;
        overrun_nxt = 1'b0;
      end else begin
        state_nxt   = IDLE;
        cfg_err_nxt = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: state_nxt = IDLE;
        RD: begin
          state_nxt = ISSUE;
          issue     = 1'b1;
        end
        ISSUE: state_nxt = WAIT_CPI;
        WAIT_CPI: begin
          if (pc_edge) begin
            state_nxt = WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (i_tx_over_flag) begin
            idx_nxt   = ({1'b0, idx_q} == last_idx) ? '0 : idx_q + ADDR_W'(1);
            state_nxt = RD;
          end else if (pc_edge) begin
            overrun_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      hop_len_q     <= '0;
      o_overrun     <= 1'b0;
      o_cfg_err     <= 1'b0;
      o_rf_freq_vld <= 1'b0;
      o_hop_idx     <= '0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      idx_q         <= idx_nxt;
      hop_len_q     <= hop_len_nxt;
      o_overrun     <= overrun_nxt;
      o_cfg_err     <= cfg_err_nxt;
      o_rf_freq_vld <= issue;
      o_busy        <= (state_nxt != IDLE);
      if (issue) begin
        o_hop_idx <= idx_q;
      end
    end
  end

  // The read is only committed when RD really advances to ISSUE, so a stop
  // or restart during RD leaves the previously issued word untouched.
  rf_hop_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .FREQ_W (FREQ_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (i_cfg_we),
    .wr_addr (i_cfg_addr),
    .wr_data (i_cfg_data),
    .rd_en   (issue),
    .rd_addr (idx_q),
    .rd_data (o_rf_freq)
  );

endmodule

// File: tb/tb_rf_hop_sched.sv
// Self-checking bench for rf_hop_sched: directed scenarios plus randomized
// CPI sequences checked against a table/index model.
module tb_rf_hop_sched;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int FREQ_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_cfg_we = 1'b0;
  logic [ADDR_W-1:0] i_cfg_addr = '0;
  logic [FREQ_W-1:0] i_cfg_data = '0;
  logic [ADDR_W:0]   i_hop_len = '0;
  logic              i_init = 1'b0;
  logic              i_stop = 1'b0;
  logic              i_pre_cpi = 1'b0;
  logic              i_tx_over_flag = 1'b0;
  logic [FREQ_W-1:0] o_rf_freq;
  logic              o_rf_freq_vld;
  logic [ADDR_W-1:0] o_hop_idx;
  logic              o_busy;
  logic              o_overrun;
  logic              o_cfg_err;

  int total = 0;
  int bad   = 0;

  // Reference model: table contents, active length, next index to issue and
  // the last issued word/index.
  logic [FREQ_W-1:0] ref_tbl [DEPTH];
  int                model_len  = 1;
  int                model_next = 0;
  logic [FREQ_W-1:0] last_w     = '0;
  int                last_i     = 0;

  always #5 clk = ~clk;

  rf_hop_sched #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .FREQ_W (FREQ_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_cfg_we       (i_cfg_we),
    .i_cfg_addr     (i_cfg_addr),
    .i_cfg_data     (i_cfg_data),
    .i_hop_len      (i_hop_len),
    .i_init         (i_init),
    .i_stop         (i_stop),
    .i_pre_cpi      (i_pre_cpi),
    .i_tx_over_flag (i_tx_over_flag),
    .o_rf_freq      (o_rf_freq),
    .o_rf_freq_vld  (o_rf_freq_vld),
    .o_hop_idx      (o_hop_idx),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun),
    .o_cfg_err      (o_cfg_err)
  );

  task automatic wr_entry(input int a, input logic [FREQ_W-1:0] d);
    i_cfg_we   = 1'b1;
    i_cfg_addr = ADDR_W'(a);
    i_cfg_data = d;
    @(negedge clk);
    i_cfg_we = 1'b0;
    ref_tbl[a] = d;
  endtask

  task automatic pulse_init(input int len);
    i_hop_len = (ADDR_W+1)'(len);
    i_init    = 1'b1;
    @(negedge clk);
    i_init = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({o_rf_freq, o_rf_freq_vld, o_hop_idx, o_busy, o_overrun, o_cfg_err} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got freq=%h vld=%b idx=%0d busy=%b ovr=%b err=%b want all 0",
               o_rf_freq, o_rf_freq_vld, o_hop_idx, o_busy, o_overrun, o_cfg_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Accepted init: vld two cycles after init, carrying entry 0.
  task automatic test_init_issue(input string tag, input int len);
    pulse_init(len);
    total++;
    if (o_rf_freq_vld !== 1'b0 || o_busy !== 1'b1 || o_cfg_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_rd_cycle got vld=%b busy=%b err=%b want vld=0 busy=1 err=0",
               tag, o_rf_freq_vld, o_busy, o_cfg_err);
    end
    @(negedge clk);
    total++;
    if (o_rf_freq_vld !== 1'b1 || o_rf_freq !== ref_tbl[0] || o_hop_idx !== '0) begin
      bad++;
      $display("[TB] FAIL %s_first_issue got vld=%b freq=%h idx=%0d want vld=1 freq=%h idx=0",
               tag, o_rf_freq_vld, o_rf_freq, o_hop_idx, ref_tbl[0]);
    end
    @(negedge clk);
    total++;
    if (o_rf_freq_vld !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_vld_width got vld=%b want 0", tag, o_rf_freq_vld);
    end
    model_len  = len;
    model_next = 1 % len;
    last_w     = ref_tbl[0];
    last_i     = 0;
  endtask

  // One pre_cpi -> tx_over cycle from WAIT_CPI; optionally a stray tx_over
  // first (ignored) and a colliding write to the word being read.
  task automatic test_cpi(input string tag, input bit extra_tx, input int gap,
                          input bit collide, input logic [FREQ_W-1:0] new_w);
    int                exp_i;
    logic [FREQ_W-1:0] exp_w;
    bit                seen;
    if (extra_tx) begin
      i_tx_over_flag = 1'b1;
      @(negedge clk);
      i_tx_over_flag = 1'b0;
      seen = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (o_rf_freq_vld) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s_stray_tx got vld=1 want no vld", tag);
      end
    end
    i_pre_cpi = 1'b1;
    repeat (4) @(negedge clk);
    i_pre_cpi = 1'b0;
    repeat (3 + gap) @(negedge clk);
    exp_i = model_next;
    exp_w = ref_tbl[exp_i];
    i_tx_over_flag = 1'b1;
    @(negedge clk);
    i_tx_over_flag = 1'b0;
    if (collide) begin
      i_cfg_we   = 1'b1;
      i_cfg_addr = ADDR_W'(exp_i);
      i_cfg_data = new_w;
    end
    total++;
    if (o_rf_freq_vld !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_early_vld got vld=%b want 0", tag, o_rf_freq_vld);
    end
    @(negedge clk);
    i_cfg_we = 1'b0;
    total++;
    if (o_rf_freq_vld !== 1'b1 || o_rf_freq !== exp_w || o_hop_idx !== ADDR_W'(exp_i)) begin
      bad++;
      $display("[TB] FAIL %s_issue got vld=%b freq=%h idx=%0d want vld=1 freq=%h idx=%0d",
               tag, o_rf_freq_vld, o_rf_freq, o_hop_idx, exp_w, exp_i);
    end
    @(negedge clk);
    total++;
    if (o_rf_freq_vld !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_vld_width got vld=%b want 0", tag, o_rf_freq_vld);
    end
    if (collide) ref_tbl[exp_i] = new_w;
    last_w     = exp_w;
    last_i     = exp_i;
    model_next = (model_next + 1) % model_len;
  endtask

  task automatic test_basic();
    wr_entry(0, 16'h1111);
    wr_entry(1, 16'h2222);
    wr_entry(2, 16'h3333);
    repeat (4) @(negedge clk);
    test_init_issue("basic", 3);
  endtask

  task automatic test_wrap();
    logic [FREQ_W-1:0] want [4];
    want[0] = 16'h2222;
    want[1] = 16'h3333;
    want[2] = 16'h1111;
    want[3] = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      test_cpi("wrap", 1'b0, k, 1'b0, '0);
      total++;
      if (o_rf_freq !== want[k]) begin
        bad++;
        $display("[TB] FAIL wrap_seq%0d got freq=%h want %h", k, o_rf_freq, want[k]);
      end
    end
  endtask

  task automatic test_overrun();
    bit seen;
    i_pre_cpi = 1'b1;
    repeat (4) @(negedge clk);
    i_pre_cpi = 1'b0;
    repeat (3) @(negedge clk);
    i_pre_cpi = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (o_rf_freq_vld) seen = 1'b1;
      if (c == 3) begin
        total++;
        if (o_overrun !== 1'b0) begin
          bad++;
          $display("[TB] FAIL overrun_early got ovr=%b want 0", o_overrun);
        end
      end
    end
    total++;
    if (o_overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL overrun_set got ovr=%b want 1", o_overrun);
    end
    i_pre_cpi = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_rf_freq_vld) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || o_overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL overrun_hold got vld_seen=%b ovr=%b want vld_seen=0 ovr=1", seen, o_overrun);
    end
  endtask

  task automatic test_stop_beats_init();
    bit seen;
    i_stop    = 1'b1;
    i_init    = 1'b1;
    i_hop_len = 5'd3;
    @(negedge clk);
    i_stop = 1'b0;
    i_init = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_rf_freq_vld !== 1'b0 || o_cfg_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stop_idle got busy=%b vld=%b err=%b want 0 0 0", o_busy, o_rf_freq_vld, o_cfg_err);
    end
    seen = 1'b0;
    i_tx_over_flag = 1'b1;
    @(negedge clk);
    i_tx_over_flag = 1'b0;
    if (o_rf_freq_vld) seen = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (o_rf_freq_vld || o_busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || o_rf_freq !== last_w || o_hop_idx !== ADDR_W'(last_i) || o_overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stop_hold got act=%b freq=%h idx=%0d ovr=%b want act=0 freq=%h idx=%0d ovr=1",
               seen, o_rf_freq, o_hop_idx, o_overrun, last_w, last_i);
    end
  endtask

  task automatic test_rejected_init();
    int lens [2];
    lens[0] = 0;
    lens[1] = 17;
    for (int k = 0; k < 2; k++) begin
      pulse_init(lens[k]);
      total++;
      if (o_cfg_err !== 1'b1 || o_busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reject_len%0d got err=%b busy=%b want err=1 busy=0", lens[k], o_cfg_err, o_busy);
      end
      @(negedge clk);
      total++;
      if (o_cfg_err !== 1'b0 || o_rf_freq_vld !== 1'b0 || o_busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reject_pulse%0d got err=%b vld=%b busy=%b want 0 0 0",
                 lens[k], o_cfg_err, o_rf_freq_vld, o_busy);
      end
    end
    total++;
    if (o_overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reject_keeps_ovr got ovr=%b want 1", o_overrun);
    end
    for (int a = 3; a < DEPTH; a++) wr_entry(a, FREQ_W'($urandom));
    test_init_issue("len16", 16);
    total++;
    if (o_overrun !== 1'b0) begin
      bad++;
      $display("[TB] FAIL init_clears_ovr got ovr=%b want 0", o_overrun);
    end
    pulse_init(0);
    total++;
    if (o_cfg_err !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reject_running got err=%b busy=%b want err=1 busy=0", o_cfg_err, o_busy);
    end
    @(negedge clk);
  endtask

  task automatic test_collision();
    logic [FREQ_W-1:0] new_w;
    test_init_issue("coll", 1);
    new_w = ~ref_tbl[0];
    test_cpi("coll_old", 1'b0, 0, 1'b1, new_w);
    test_cpi("coll_new", 1'b0, 1, 1'b0, '0);
    total++;
    if (o_rf_freq !== new_w) begin
      bad++;
      $display("[TB] FAIL coll_lands got freq=%h want %h", o_rf_freq, new_w);
    end
  endtask

  task automatic test_random();
    int len;
    len = $urandom_range(2, DEPTH);
    test_init_issue("rnd", len);
    i_hop_len = (ADDR_W+1)'($urandom);
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 1) == 1) wr_entry($urandom_range(0, DEPTH-1), FREQ_W'($urandom));
      test_cpi("rnd", 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid_run();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({o_rf_freq, o_rf_freq_vld, o_hop_idx, o_busy, o_overrun, o_cfg_err} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs got freq=%h vld=%b idx=%0d busy=%b ovr=%b err=%b want all 0",
               o_rf_freq, o_rf_freq_vld, o_hop_idx, o_busy, o_overrun, o_cfg_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_init_issue("after_reset", 5);
    test_cpi("after_reset", 1'b0, 0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overrun();
    test_stop_beats_init();
    test_rejected_init();
    test_collision();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
